riscv_iram_arbiter: RTL and testbench

- Shares the single-port instruction RAM model between two block-read requesters.
  - Port 0: I-cache refill.
  - Port 1: prefetch/loader.
- Owns the memory handshake:
  - holds mem_rden until mem_ready;
  - captures the 128-bit block;
  - returns the block to the granted requester;
  - drops mem_rden between transactions so the memory latency counter restarts.
- Sits between the instruction cache controller and the instruction RAM.

---
 rtl/riscv_iram_arbiter.sv | 109 ++++++++++
 tb/tb_riscv_iram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_iram_arbiter.sv
// Two-port block-read arbiter in front of the single-port instruction RAM.
// Port 0 is I-cache refill and port 1 is the prefetch/loader; define IRAM_ARB_RR_EN for round-robin ties.
module riscv_iram_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [S_ADDR-1:0]     addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic [S_ADDR-1:0]     addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  flush,
    output logic                  busy,
    output logic                  mem_rden,
    output logic [S_ADDR-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       owner;
    logic       kill;
    logic       any_req;
    logic       sel;

    // Handshakes: a requester holds reqN and addrN stable until gntN; the
    // transfer happens at the rising edge where both are high. rvalidN is a
    // one-cycle pulse with no backpressure. On the memory side mem_rden is
    // held with a stable mem_addr until mem_ready, then dropped for >= 1 cycle.
    assign any_req = req0 | req1;

`ifdef IRAM_ARB_RR_EN
    logic last_owner;

    always_comb begin
        sel = req1;
        if (req0 && req1) sel = ~last_owner;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_owner <= sel;
        end
    end
`else
    assign sel = ~req0;
`endif

    // Grants are combinational so the requester sees them in its request cycle.
    assign gnt0      = rst && (state == IDLE) && any_req && !sel;
    assign gnt1      = rst && (state == IDLE) && any_req && sel;
    assign mem_rden  = (state == READ);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            kill     <= 1'b0;
            mem_addr <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            rvalid0 <= (state == RESP) && !kill && !owner;
            rvalid1 <= (state == RESP) && !kill && owner;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_addr <= sel ? addr1 : addr0;
                        owner    <= sel;
                        state    <= READ;
                    end
                end
                READ: begin
                    // A killed refill still lands in rdata0; only its pulse is dropped.
                    if (flush && !owner) kill <= 1'b1;
                    if (mem_ready) begin
                        if (owner) rdata1 <= mem_rdata;
                        else       rdata0 <= mem_rdata;
                        state <= RESP;
                    end
                end
                RESP: begin
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_iram_arbiter.sv
// Directed bench for riscv_iram_arbiter: a vector table of single transactions
// plus hand-written tie, round-robin, stray-ready and reset-mid-read sequences.
module tb_riscv_iram_arbiter;

    localparam int DW = 128;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, flush;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_rden, mem_ready;
    logic [DW-1:0] rdata0, rdata1, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    // Memory model: ready in the lat_cfg-th cycle of a held rden.
    logic [3:0]    lat_cfg;
    logic [3:0]    rden_cnt;
    logic          stray;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_rd [2];

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        int            lat;
        int            flush_cyc;
        bit            exp_rv;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [7];

    riscv_iram_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .flush(flush), .busy(busy), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
        blk = {32{a[3:0]}} ^ {{118{1'b0}}, a} ^ {a, {118{1'b0}}}
              ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    assign mem_rdata = blk(mem_addr);
    assign mem_ready = stray | (mem_rden && (rden_cnt == lat_cfg - 4'd1));

    always_ff @(posedge clk) begin
        if (!mem_rden)      rden_cnt <= 4'd0;
        else if (!mem_ready) rden_cnt <= rden_cnt + 4'd1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rdata(input string tag);
        chk({tag, " rdata0"}, rdata0, exp_rd[0]);
        chk({tag, " rdata1"}, rdata1, exp_rd[1]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rv_cyc, rv_n, rden_n;
        bit other_rv;
        @(negedge clk);
        lat_cfg = 4'(v.lat);
        if (v.port == 0) begin req0 = 1'b1; addr0 = v.addr; end
        else             begin req1 = 1'b1; addr1 = v.addr; end
        flush = (v.flush_cyc == 0);
        #1;
        chk({tag, " gnt0"}, DW'(gnt0), DW'(v.port == 0));
        chk({tag, " gnt1"}, DW'(gnt1), DW'(v.port == 1));
        rv_cyc = -1; rv_n = 0; rden_n = 0; other_rv = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b0;
            flush = (v.flush_cyc == c);
            #1;
            if (mem_rden) rden_n++;
            if (c == 1) chk({tag, " mem_addr"}, DW'(mem_addr), DW'(v.addr));
            if ((v.port == 0 ? rvalid0 : rvalid1) === 1'b1) begin
                rv_n++;
                if (rv_cyc < 0) rv_cyc = c;
            end
            if ((v.port == 0 ? rvalid1 : rvalid0) === 1'b1) other_rv = 1'b1;
        end
        flush = 1'b0;
        exp_rd[v.port] = blk(v.addr);
        chk({tag, " rden cycles"}, DW'(rden_n), DW'(v.lat));
        chk({tag, " rvalid cycle"}, DW'(rv_cyc), DW'(v.exp_rv ? v.exp_cyc : -1));
        chk({tag, " rvalid count"}, DW'(rv_n), DW'(v.exp_rv ? 1 : 0));
        chk({tag, " other rvalid"}, DW'(other_rv), DW'(0));
        chk_rdata(tag);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order_q[$];
        logic [AW-1:0] addr_q[$];
        int exp_order [4];
        int gap, low_run, rv0_n, rv1_n;
        bit seen_rden, g0, g1, prev_rden;

        // Single-transaction vectors; exp_cyc = lat + 2 counted from the grant cycle.
        vecs[0] = '{port: 0, addr: 10'h03A, lat: 3, flush_cyc: -1, exp_rv: 1'b1, exp_cyc: 5};
        vecs[1] = '{port: 1, addr: 10'h001, lat: 1, flush_cyc: -1, exp_rv: 1'b1, exp_cyc: 3};
        vecs[2] = '{port: 0, addr: 10'h3FF, lat: 5, flush_cyc: -1, exp_rv: 1'b1, exp_cyc: 7};
        vecs[3] = '{port: 0, addr: 10'h100, lat: 3, flush_cyc: 2,  exp_rv: 1'b0, exp_cyc: 0};
        vecs[4] = '{port: 1, addr: 10'h055, lat: 2, flush_cyc: 2,  exp_rv: 1'b1, exp_cyc: 4};
        vecs[5] = '{port: 0, addr: 10'h0AA, lat: 2, flush_cyc: 0,  exp_rv: 1'b1, exp_cyc: 4};
        vecs[6] = '{port: 0, addr: 10'h000, lat: 4, flush_cyc: 5,  exp_rv: 1'b1, exp_cyc: 6};

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; flush = 1'b0; stray = 1'b0;
        addr0 = '0; addr1 = '0; lat_cfg = 4'd1;
        exp_rd[0] = '0; exp_rd[1] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("reset gnt0", DW'(gnt0), DW'(0));
        chk("reset gnt1", DW'(gnt1), DW'(0));
        chk("reset rvalid0", DW'(rvalid0), DW'(0));
        chk("reset rvalid1", DW'(rvalid1), DW'(0));
        chk("reset mem_rden", DW'(mem_rden), DW'(0));
        chk("reset busy", DW'(busy), DW'(0));
        chk("reset mem_addr", DW'(mem_addr), DW'(0));
        chk("reset state", DW'(dbg_state), DW'(0));
        chk_rdata("reset");
        rst = 1'b1;

        // Tie: port 0 first, then port 1, with a rden-low gap between them.
        @(negedge clk);
        lat_cfg = 4'd2;
        req0 = 1'b1; addr0 = 10'h010;
        req1 = 1'b1; addr1 = 10'h020;
        g0 = 1'b0; g1 = 1'b0; prev_rden = 1'b0; seen_rden = 1'b0;
        gap = -1; low_run = 0; rv0_n = 0; rv1_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (g0) req0 = 1'b0;
            if (g1) req1 = 1'b0;
            #1;
            g0 = gnt0; g1 = gnt1;
            if (gnt0) order_q.push_back(0);
            if (gnt1) order_q.push_back(1);
            if (mem_rden && !prev_rden) begin
                addr_q.push_back(mem_addr);
                if (seen_rden && gap < 0) gap = low_run;
                seen_rden = 1'b1;
            end
            low_run = mem_rden ? 0 : low_run + 1;
            prev_rden = mem_rden;
            if (rvalid0) rv0_n++;
            if (rvalid1) rv1_n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie grant count", DW'(order_q.size()), DW'(2));
        if (order_q.size() >= 2) begin
            chk("tie first grant", DW'(order_q[0]), DW'(0));
            chk("tie second grant", DW'(order_q[1]), DW'(1));
        end
        chk("tie mem_addr count", DW'(addr_q.size()), DW'(2));
        if (addr_q.size() >= 2) begin
            chk("tie mem_addr first", DW'(addr_q[0]), DW'(10'h010));
            chk("tie mem_addr second", DW'(addr_q[1]), DW'(10'h020));
        end
        chk("tie rden gap >= 1", DW'(gap >= 1), DW'(1));
        chk("tie rvalid0 count", DW'(rv0_n), DW'(1));
        chk("tie rvalid1 count", DW'(rv1_n), DW'(1));
        exp_rd[0] = blk(10'h010);
        exp_rd[1] = blk(10'h020);
        chk_rdata("tie");

        // Vector table.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // mem_ready outside READ must be ignored.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stray = 1'b1;
            #1;
            chk("stray busy", DW'(busy), DW'(0));
            chk("stray rden", DW'(mem_rden), DW'(0));
            chk("stray rvalid", DW'({rvalid0, rvalid1}), DW'(0));
        end
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        #1;
        chk("stray state", DW'(dbg_state), DW'(0));
        chk_rdata("stray");

        // Reset in the middle of a READ.
        @(negedge clk);
        lat_cfg = 4'd6;
        req0 = 1'b1; addr0 = 10'h0F0;
        #1;
        chk("rstmid gnt0", DW'(gnt0), DW'(1));
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid rden before", DW'(mem_rden), DW'(1));
        rst = 1'b0;
        req0 = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        #1;
        chk("rstmid rden", DW'(mem_rden), DW'(0));
        chk("rstmid busy", DW'(busy), DW'(0));
        chk("rstmid gnt", DW'({gnt0, gnt1}), DW'(0));
        chk("rstmid rvalid", DW'({rvalid0, rvalid1}), DW'(0));
        chk("rstmid state", DW'(dbg_state), DW'(0));
        chk_rdata("rstmid");
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0;
        rst = 1'b1;
        rv0_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (rvalid0 || rvalid1 || busy) rv0_n++;
        end
        chk("rstmid no late activity", DW'(rv0_n), DW'(0));
        run_vec('{port: 1, addr: 10'h001, lat: 1, flush_cyc: -1, exp_rv: 1'b1, exp_cyc: 3}, "rstmid req1");

        // Both requesters held for four grants after a fresh reset.
        pulse_reset();
`ifdef IRAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        order_q.delete();
        @(negedge clk);
        lat_cfg = 4'd1;
        req0 = 1'b1; addr0 = 10'h111;
        req1 = 1'b1; addr1 = 10'h222;
        for (int c = 0; c < 30 && order_q.size() < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (gnt0) order_q.push_back(0);
            if (gnt1) order_q.push_back(1);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        chk("hold grant count", DW'(order_q.size()), DW'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < order_q.size())
                chk($sformatf("hold grant %0d", k), DW'(order_q[k]), DW'(exp_order[k]));
        end
        repeat (8) @(negedge clk);
        #1;
        chk("hold final idle", DW'(busy), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
